// File: rtl/miller_rabin_pkg.sv
// Shared types and constants for the Miller-Rabin primality tester.
package miller_rabin_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DECOMP,
    S_BASE,
    S_EXP,
    S_CHECK,
    S_SQUARE,
    S_NEXT,
    S_DONE
  } mr_state_t;

  // Round index; rounds run 0..security_parameter.
  typedef logic [1:0] round_t;

  localparam logic [7:0] MR_BASES [4] = '{8'd2, 8'd7, 8'd61, 8'd3};

endpackage

// File: rtl/miller_rabin_prime_test_mod_mul.sv
// Interleaved shift-add modular multiplier: result = a*b mod m, one bit of b per cycle.
module mod_mul #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic [WORD_WIDTH-1:0] m,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] result
);

  localparam int XW   = WORD_WIDTH + 2;
  localparam int CNTW = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] a_q, b_q, m_q, r_q, r_next;
  logic [CNTW-1:0]       cnt_q;
  logic                  busy_q, done_q;
  logic [XW-1:0]         m_x, t_dbl, t_red, t_add;

  // r stays below m: 2r < 2m, one subtraction; +a < 2m, one more subtraction.
  always_comb begin
    m_x    = {2'b00, m_q};
    t_dbl  = {1'b0, r_q, 1'b0};
    t_red  = (t_dbl >= m_x) ? t_dbl - m_x : t_dbl;
    t_add  = t_red + (b_q[WORD_WIDTH-1] ? {2'b00, a_q} : '0);
    r_next = (t_add >= m_x) ? WORD_WIDTH'(t_add - m_x) : t_add[WORD_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      m_q    <= m;
      r_q    <= '0;
      cnt_q  <= CNTW'(WORD_WIDTH);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      r_q   <= r_next;
      b_q   <= {b_q[WORD_WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CNTW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = r_q;

endmodule

// File: rtl/miller_rabin_prime_test.sv
// Sequential Miller-Rabin tester with fixed bases {2,7,61,3}; one shared modular multiplier.
module miller_rabin_prime_test
  import miller_rabin_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] n,
  input  logic [1:0]            security_parameter,
  output logic                  done,
  output logic                  is_prime,
  output mr_state_t             state_dbg
);

  localparam int CW = $clog2(WORD_WIDTH);

  mr_state_t             state_q, state_d;
  logic [WORD_WIDTH-1:0] n_q, d_q, a_q, x_q, nm1;
  logic [CW-1:0]         s_q, bit_idx_q, sq_left_q;
  round_t                round_q, sp_q;
  logic                  mul_wait_q, mul_sq_q, need_mul_q, first_q, result_q;

  logic                  mm_start, mm_busy, mm_done;
  logic [WORD_WIDTH-1:0] mm_b, mm_result;
  logic accept, is23, trivial, reducing, mul_fin, exp_bit_done, chk_pass, last_round;

  always_comb begin
    nm1          = n_q - WORD_WIDTH'(1);
    accept       = enable && (state_q == S_IDLE || state_q == S_DONE);
    is23         = (n_q == WORD_WIDTH'(2)) || (n_q == WORD_WIDTH'(3));
    trivial      = (n_q < WORD_WIDTH'(2)) || is23 || !n_q[0];
    reducing     = (a_q >= n_q);
    mul_fin      = mul_wait_q && mm_done;
    exp_bit_done = mul_fin && !(mul_sq_q && d_q[bit_idx_q]);
    chk_pass     = (x_q == nm1) || (first_q && x_q == WORD_WIDTH'(1));
    last_round   = (round_q == sp_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LOAD;
      S_LOAD:   state_d = trivial ? S_DONE : S_DECOMP;
      S_DECOMP: if (d_q[0]) state_d = S_BASE;
      S_BASE:   if (!reducing) state_d = (a_q == '0) ? S_NEXT : S_EXP;
      S_EXP:    if (exp_bit_done && bit_idx_q == '0) state_d = S_CHECK;
      S_CHECK: begin
        if (chk_pass)             state_d = S_NEXT;
        else if (sq_left_q != '0) state_d = S_SQUARE;
        else                      state_d = S_DONE;
      end
      S_SQUARE: if (mul_fin) state_d = S_CHECK;
      S_NEXT:   state_d = last_round ? S_DONE : S_BASE;
      S_DONE:   if (accept) state_d = S_LOAD;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mm_start  = (state_q == S_EXP || state_q == S_SQUARE) && !mul_wait_q && !mm_busy;
    mm_b      = (state_q == S_EXP && need_mul_q) ? a_q : x_q;
    done      = (state_q == S_DONE);
    is_prime  = result_q;
    state_dbg = state_q;
  end

  // Datapath: x accumulates a^d by squaring every bit of d and multiplying by a on set bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q        <= '0;
      d_q        <= '0;
      a_q        <= '0;
      x_q        <= '0;
      s_q        <= '0;
      bit_idx_q  <= '0;
      sq_left_q  <= '0;
      round_q    <= '0;
      sp_q       <= '0;
      mul_wait_q <= 1'b0;
      mul_sq_q   <= 1'b0;
      need_mul_q <= 1'b0;
      first_q    <= 1'b0;
      result_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            n_q      <= n;
            sp_q     <= security_parameter;
            result_q <= 1'b0;
          end
        end
        S_LOAD: begin
          d_q      <= nm1;
          s_q      <= '0;
          round_q  <= '0;
          a_q      <= WORD_WIDTH'(MR_BASES[0]);
          result_q <= is23;
        end
        S_DECOMP: begin
          if (!d_q[0]) begin
            d_q <= d_q >> 1;
            s_q <= s_q + 1'b1;
          end
        end
        S_BASE: begin
          if (reducing) begin
            a_q <= a_q - n_q;
          end else if (a_q != '0) begin
            x_q        <= WORD_WIDTH'(1);
            bit_idx_q  <= CW'(WORD_WIDTH - 1);
            sq_left_q  <= s_q - 1'b1;
            mul_wait_q <= 1'b0;
            need_mul_q <= 1'b0;
            first_q    <= 1'b1;
          end
        end
        S_EXP: begin
          if (mm_start) begin
            mul_wait_q <= 1'b1;
            mul_sq_q   <= !need_mul_q;
            need_mul_q <= 1'b0;
          end else if (mul_fin) begin
            mul_wait_q <= 1'b0;
            x_q        <= mm_result;
            if (mul_sq_q && d_q[bit_idx_q]) need_mul_q <= 1'b1;
            else                            bit_idx_q  <= bit_idx_q - 1'b1;
          end
        end
        S_CHECK: begin
          if (!chk_pass && sq_left_q != '0) sq_left_q <= sq_left_q - 1'b1;
        end
        S_SQUARE: begin
          if (mm_start) begin
            mul_wait_q <= 1'b1;
            mul_sq_q   <= 1'b1;
          end else if (mul_fin) begin
            mul_wait_q <= 1'b0;
            x_q        <= mm_result;
            first_q    <= 1'b0;
          end
        end
        S_NEXT: begin
          if (last_round) begin
            result_q <= 1'b1;
          end else begin
            round_q <= round_q + 1'b1;
            a_q     <= WORD_WIDTH'(MR_BASES[round_q + 1'b1]);
          end
        end
        default: ;
      endcase
    end
  end

  mod_mul #(.WORD_WIDTH(WORD_WIDTH)) u_mod_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mm_start),
    .a      (x_q),
    .b      (mm_b),
    .m      (n_q),
    .busy   (mm_busy),
    .done   (mm_done),
    .result (mm_result)
  );

endmodule

// File: tb/tb_miller_rabin_prime_test.sv
// Directed + randomized bench for miller_rabin_prime_test against an arithmetic reference model.
module tb_miller_rabin_prime_test;
  import miller_rabin_pkg::*;

  localparam int W       = 32;
  localparam int TIMEOUT = 30000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] n = '0;
  logic [1:0]   security_parameter = '0;
  logic         done, is_prime;
  mr_state_t    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  miller_rabin_prime_test #(.WORD_WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .n                  (n),
    .security_parameter (security_parameter),
    .done               (done),
    .is_prime           (is_prime),
    .state_dbg          (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: plain 64-bit modular arithmetic
  function automatic longint unsigned powmod(longint unsigned b, longint unsigned e,
                                             longint unsigned m);
    longint unsigned r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic ref_prime(longint unsigned nn, int sp);
    int unsigned bases[4] = '{2, 7, 61, 3};
    longint unsigned d, x, a;
    int s;
    logic ok;
    if (nn < 2) return 1'b0;
    if (nn == 2 || nn == 3) return 1'b1;
    if (nn % 2 == 0) return 1'b0;
    d = nn - 1;
    s = 0;
    while (d % 2 == 0) begin
      d = d / 2;
      s++;
    end
    for (int r = 0; r <= sp; r++) begin
      a = bases[r] % nn;
      if (a == 0) continue;
      x = powmod(a, d, nn);
      if (x == 1 || x == nn - 1) continue;
      ok = 1'b0;
      for (int j = 1; j < s; j++) begin
        x = (x * x) % nn;
        if (x == nn - 1) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Scoreboard comparison
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic start_run(input logic [W-1:0] nn, input logic [1:0] sp);
    @(negedge clk);
    n = nn;
    security_parameter = sp;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = $urandom;
    security_parameter = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < TIMEOUT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] nn, input logic [1:0] sp,
                           input logic expected, input bit check_lat);
    int cyc;
    logic [0:0] e;
    exp_q.push_back(expected);
    start_run(nn, sp);
    check_val({tag, "_done_fell"}, 32'(done), 32'd0);
    wait_done(cyc);
    check_val({tag, "_done"}, 32'(done), 32'd1);
    e = exp_q.pop_front();
    check_val({tag, "_is_prime"}, 32'(is_prime), 32'(e));
    if (check_lat) check_val({tag, "_latency"}, 32'(cyc), 32'd2);
  endtask

  logic [W-1:0] rn;
  logic [1:0]   rsp;
  int           cyc;

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_is_prime", 32'(is_prime), 32'd0);
    check_val("reset_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // First prime; result held until next enable
    run_check("n17", 32'd17, 2'd2, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_val("n17_hold_done", 32'(done), 32'd1);
    check_val("n17_hold_is_prime", 32'(is_prime), 32'd1);

    // Trivial cases
    run_check("n0", 32'd0, 2'd2, 1'b0, 1'b1);
    run_check("n1", 32'd1, 2'd2, 1'b0, 1'b1);
    run_check("n2", 32'd2, 2'd2, 1'b1, 1'b1);
    run_check("n3", 32'd3, 2'd2, 1'b1, 1'b1);
    run_check("n100", 32'd100, 2'd2, 1'b0, 1'b1);

    // Composites and pseudoprimes
    run_check("n561", 32'd561, 2'd2, 1'b0, 1'b0);
    run_check("n2047_sp2", 32'd2047, 2'd2, 1'b0, 1'b0);
    run_check("n2047_sp0", 32'd2047, 2'd0, 1'b1, 1'b0);
    run_check("n3215031751", 32'd3215031751, 2'd2, 1'b0, 1'b0);

    // Large primes
    run_check("n4294967291", 32'd4294967291, 2'd2, 1'b1, 1'b0);
    run_check("n2147483647", 32'd2147483647, 2'd2, 1'b1, 1'b0);

    // Reset during exponentiation
    start_run(32'd4294967291, 2'd2);
    cyc = 0;
    while (state_dbg !== S_EXP && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("reach_exp", 32'(state_dbg), 32'(S_EXP));
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_val("midrun_rst_done", 32'(done), 32'd0);
    check_val("midrun_rst_is_prime", 32'(is_prime), 32'd0);
    check_val("midrun_rst_state", 32'(state_dbg), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_check("n13_after_rst", 32'd13, 2'd2, 1'b1, 1'b0);

    // Enable while busy is ignored; result belongs to the latched n
    exp_q.push_back(1'b1);
    start_run(32'd97, 2'd1);
    repeat (20) @(negedge clk);
    n = 32'd100;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check_val("busy_enable_ignored", 32'(state_dbg == S_LOAD), 32'd0);
    wait_done(cyc);
    check_val("n97_done", 32'(done), 32'd1);
    check_val("n97_is_prime", 32'(is_prime), 32'(exp_q.pop_front()));

    // Back-to-back from DONE
    run_check("n91_b2b", 32'd91, 2'd2, 1'b0, 1'b0);

    // Randomized against the model
    for (int i = 0; i < 6; i++) begin
      if (i < 3) rn = $urandom_range(5, 65535) | 32'd1;
      else       rn = $urandom | 32'h8000_0001;
      rsp = 2'($urandom_range(0, 3));
      run_check($sformatf("rand%0d_n%0d_sp%0d", i, rn, rsp), rn, rsp,
                ref_prime({32'd0, rn}, int'(rsp)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
